mem_arbiter: RTL and testbench

Two-port arbiter and sequencer in front of `memory_controller`. The CPU fetch/load/store port and a secondary bus-master port (DMA / video copy engine) each issue single-word requests. The arbiter grants one at a time and holds `read_en`/`write_en` for a fixed number of cycles, so the byte-serial SRAM path completes both byte phases. It then drops the enables for one cycle, which resets the controller's byte phase, captures the read word and acknowledges the requester.

---
 rtl/mem_arbiter.sv | 167 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port word arbiter/sequencer in front of the byte-serial memory controller
// Grants one single-word request at a time and paces the downstream enables.
module mem_arbiter #(
   parameter int ACCESS_CYCLES = 3,
   parameter int ROUND_ROBIN   = 1
) (
   input  logic        clk,
   input  logic        rst_n,

   input  logic        p0_req,
   input  logic        p0_we,
   input  logic [15:0] p0_addr,
   input  logic [15:0] p0_wdata,
   output logic [15:0] p0_rdata,
   output logic        p0_ack,

   input  logic        p1_req,
   input  logic        p1_we,
   input  logic [15:0] p1_addr,
   input  logic [15:0] p1_wdata,
   output logic [15:0] p1_rdata,
   output logic        p1_ack,

   output logic [15:0] mem_addr,
   output logic [15:0] mem_wdata,
   output logic        mem_read_en,
   output logic        mem_write_en,
   input  logic [15:0] mem_rdata,

   output logic        busy
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_DONE   = 2'd2
   } state_t;

   localparam logic [3:0] CNT_LOAD = 4'(ACCESS_CYCLES - 1);

   state_t      state, state_nxt;
   logic [3:0]  cnt, cnt_nxt;
   logic        grant, grant_nxt;
   logic        gnt_we, gnt_we_nxt;
   logic        last_grant, last_grant_nxt;

   logic [15:0] mem_addr_nxt, mem_wdata_nxt;
   logic        mem_read_en_nxt, mem_write_en_nxt;
   logic [15:0] p0_rdata_nxt, p1_rdata_nxt;
   logic        p0_ack_nxt, p1_ack_nxt;
   logic        busy_nxt;

   logic        elig0, elig1;
   logic        pick;
   logic        pick_we;
   logic [15:0] pick_addr, pick_wdata;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= ST_IDLE;
         cnt          <= 4'd0;
         grant        <= 1'b0;
         gnt_we       <= 1'b0;
         last_grant   <= 1'b1;
         mem_addr     <= 16'd0;
         mem_wdata    <= 16'd0;
         mem_read_en  <= 1'b0;
         mem_write_en <= 1'b0;
         p0_rdata     <= 16'd0;
         p1_rdata     <= 16'd0;
         p0_ack       <= 1'b0;
         p1_ack       <= 1'b0;
         busy         <= 1'b0;
      end else begin
         state        <= state_nxt;
         cnt          <= cnt_nxt;
         grant        <= grant_nxt;
         gnt_we       <= gnt_we_nxt;
         last_grant   <= last_grant_nxt;
         mem_addr     <= mem_addr_nxt;
         mem_wdata    <= mem_wdata_nxt;
         mem_read_en  <= mem_read_en_nxt;
         mem_write_en <= mem_write_en_nxt;
         p0_rdata     <= p0_rdata_nxt;
         p1_rdata     <= p1_rdata_nxt;
         p0_ack       <= p0_ack_nxt;
         p1_ack       <= p1_ack_nxt;
         busy         <= busy_nxt;
      end
   end

   // A port whose ack is on the wire this cycle is masked so a held req is not re-granted.
   always_comb begin
      elig0 = p0_req & ~p0_ack;
      elig1 = p1_req & ~p1_ack;

      if (elig0 && elig1) begin
         pick = (ROUND_ROBIN != 0) ? ~last_grant : 1'b0;
      end else begin
         pick = elig1;
      end

      pick_we    = pick ? p1_we    : p0_we;
      pick_addr  = pick ? p1_addr  : p0_addr;
      pick_wdata = pick ? p1_wdata : p0_wdata;
   end

   always_comb begin
      state_nxt        = state;
      cnt_nxt          = cnt;
      grant_nxt        = grant;
      gnt_we_nxt       = gnt_we;
      last_grant_nxt   = last_grant;
      mem_addr_nxt     = mem_addr;
      mem_wdata_nxt    = mem_wdata;
      mem_read_en_nxt  = mem_read_en;
      mem_write_en_nxt = mem_write_en;
      p0_rdata_nxt     = p0_rdata;
      p1_rdata_nxt     = p1_rdata;
      p0_ack_nxt       = 1'b0;
      p1_ack_nxt       = 1'b0;
      busy_nxt         = busy;

      case (state)
         ST_IDLE: begin
            if (elig0 || elig1) begin
               grant_nxt        = pick;
               gnt_we_nxt       = pick_we;
               mem_addr_nxt     = pick_addr;
               mem_wdata_nxt    = pick_wdata;
               mem_read_en_nxt  = ~pick_we;
               mem_write_en_nxt = pick_we;
               cnt_nxt          = CNT_LOAD;
               busy_nxt         = 1'b1;
               state_nxt        = ST_ACCESS;
            end
         end

         ST_ACCESS: begin
            if (cnt == 4'd0) begin
               mem_read_en_nxt  = 1'b0;
               mem_write_en_nxt = 1'b0;
               state_nxt        = ST_DONE;
            end else begin
               cnt_nxt = cnt - 4'd1;
            end
         end

         ST_DONE: begin
            if (!gnt_we) begin
               if (grant) p1_rdata_nxt = mem_rdata;
               else       p0_rdata_nxt = mem_rdata;
            end
            p0_ack_nxt     = ~grant;
            p1_ack_nxt     = grant;
            last_grant_nxt = grant;
            busy_nxt       = 1'b0;
            state_nxt      = ST_IDLE;
         end

         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - bench for mem_arbiter, round-robin and fixed-priority instances
// Expected values come from a transaction timeline model: grant cycle plus fixed offsets.
module tb_mem_arbiter;

   localparam int AC = 3;

   logic        clk;
   logic        rst_n;
   logic        req     [2][2];
   logic        we      [2][2];
   logic [15:0] addr    [2][2];
   logic [15:0] wdata   [2][2];
   logic [15:0] rdata   [2][2];
   logic        ack     [2][2];
   logic [15:0] m_addr  [2];
   logic [15:0] m_wdata [2];
   logic        m_re    [2];
   logic        m_we    [2];
   logic [15:0] rd_word [2];
   logic        busy    [2];

   for (genvar g = 0; g < 2; g++) begin : g_dut
      mem_arbiter #(
         .ACCESS_CYCLES(AC),
         .ROUND_ROBIN  (g == 0 ? 1 : 0)
      ) u_dut (
         .clk         (clk),
         .rst_n       (rst_n),
         .p0_req      (req[g][0]),
         .p0_we       (we[g][0]),
         .p0_addr     (addr[g][0]),
         .p0_wdata    (wdata[g][0]),
         .p0_rdata    (rdata[g][0]),
         .p0_ack      (ack[g][0]),
         .p1_req      (req[g][1]),
         .p1_we       (we[g][1]),
         .p1_addr     (addr[g][1]),
         .p1_wdata    (wdata[g][1]),
         .p1_rdata    (rdata[g][1]),
         .p1_ack      (ack[g][1]),
         .mem_addr    (m_addr[g]),
         .mem_wdata   (m_wdata[g]),
         .mem_read_en (m_re[g]),
         .mem_write_en(m_we[g]),
         .mem_rdata   (rd_word[g]),
         .busy        (busy[g])
      );
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;

   // Per instance: cycle of the last grant and what was latched then.
   int          t0    [2];
   int          gp    [2];
   bit          gwe   [2];
   logic [15:0] ga    [2];
   logic [15:0] gd    [2];
   int          lastg [2];
   logic [15:0] e_rd  [2][2];

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   function automatic bit exp_ack(input int i, input int p);
      return (cyc == t0[i] + AC + 2) && (gp[i] == p);
   endfunction

   task automatic reset_model();
      for (int i = 0; i < 2; i++) begin
         t0[i]    = -100;
         gp[i]    = 0;
         gwe[i]   = 1'b0;
         ga[i]    = 16'h0000;
         gd[i]    = 16'h0000;
         lastg[i] = 1;
         for (int p = 0; p < 2; p++) e_rd[i][p] = 16'h0000;
      end
   endtask

   task automatic check_cycle();
      for (int i = 0; i < 2; i++) begin
         bit en;
         bit bz;
         en = (cyc >= t0[i] + 1) && (cyc <= t0[i] + AC);
         bz = (cyc >= t0[i] + 1) && (cyc <= t0[i] + AC + 1);
         chk($sformatf("u%0d.mem_read_en", i),  16'(m_re[i]), 16'(en && !gwe[i]));
         chk($sformatf("u%0d.mem_write_en", i), 16'(m_we[i]), 16'(en && gwe[i]));
         chk($sformatf("u%0d.busy", i),         16'(busy[i]), 16'(bz));
         chk($sformatf("u%0d.mem_addr", i),     m_addr[i], ga[i]);
         chk($sformatf("u%0d.mem_wdata", i),    m_wdata[i], gd[i]);
         for (int p = 0; p < 2; p++) begin
            chk($sformatf("u%0d.p%0d_ack", i, p),   16'(ack[i][p]), 16'(exp_ack(i, p)));
            chk($sformatf("u%0d.p%0d_rdata", i, p), rdata[i][p], e_rd[i][p]);
         end
      end
   endtask

   // Applied just before the clock edge that ends cycle `cyc`.
   task automatic model_edge();
      for (int i = 0; i < 2; i++) begin
         bit el0;
         bit el1;
         int g;
         if (rst_n !== 1'b1) continue;
         if (cyc == t0[i] + AC + 1) begin
            if (!gwe[i]) e_rd[i][gp[i]] = rd_word[i];
            lastg[i] = gp[i];
         end
         if (cyc > t0[i] + AC + 1) begin
            el0 = req[i][0] && !exp_ack(i, 0);
            el1 = req[i][1] && !exp_ack(i, 1);
            g = -1;
            if (el0 && el1)  g = (i == 0) ? 1 - lastg[i] : 0;
            else if (el0)    g = 0;
            else if (el1)    g = 1;
            if (g >= 0) begin
               t0[i]  = cyc;
               gp[i]  = g;
               gwe[i] = we[i][g];
               ga[i]  = addr[i][g];
               gd[i]  = wdata[i][g];
            end
         end
      end
   endtask

   task automatic tick();
      model_edge();
      @(posedge clk);
      #1;
      cyc++;
      check_cycle();
   endtask

   task automatic new_fields(input int i, input int p);
      we[i][p]    = 1'($urandom_range(0, 1));
      addr[i][p]  = 16'($urandom);
      wdata[i][p] = 16'($urandom);
   endtask

   task automatic serve(input int i, input int p, input bit w, input logic [15:0] a,
                        input logic [15:0] d, output int lat);
      int c0;
      c0 = cyc;
      lat = -1;
      req[i][p]   = 1'b1;
      we[i][p]    = w;
      addr[i][p]  = a;
      wdata[i][p] = d;
      for (int n = 0; n < 30 && lat < 0; n++) begin
         tick();
         if (ack[i][p] === 1'b1) begin
            lat = cyc - c0;
            req[i][p] = 1'b0;
         end
      end
      req[i][p] = 1'b0;
   endtask

   task automatic contend(input int i, input int ncyc, output int n0, output int n1);
      n0 = 0;
      n1 = 0;
      for (int p = 0; p < 2; p++) begin
         req[i][p] = 1'b1;
         new_fields(i, p);
      end
      for (int n = 0; n < ncyc; n++) begin
         tick();
         if (ack[i][0] === 1'b1) begin n0++; new_fields(i, 0); end
         if (ack[i][1] === 1'b1) begin n1++; new_fields(i, 1); end
      end
      req[i][0] = 1'b0;
      req[i][1] = 1'b0;
      for (int n = 0; n < 8; n++) tick();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      int n0;
      int n1;

      rst_n = 1'b0;
      for (int i = 0; i < 2; i++) begin
         rd_word[i] = 16'h0000;
         for (int p = 0; p < 2; p++) begin
            req[i][p]   = 1'b0;
            we[i][p]    = 1'b0;
            addr[i][p]  = 16'h0000;
            wdata[i][p] = 16'h0000;
         end
      end
      reset_model();

      @(posedge clk);
      #1;
      check_cycle();
      tick();
      tick();
      rst_n = 1'b1;
      tick();

      // Single read on port 0.
      rd_word[0] = 16'h4400;
      serve(0, 0, 1'b0, 16'h0100, 16'h0000, lat);
      chk("read_latency", 16'(lat), 16'(AC + 2));
      chk("read_rdata", rdata[0][0], 16'h4400);
      tick();

      // Single write on port 1.
      rd_word[0] = 16'hBEEF;
      serve(0, 1, 1'b1, 16'hF830, 16'h1234, lat);
      chk("write_latency", 16'(lat), 16'(AC + 2));
      chk("write_rdata_hold", rdata[0][1], 16'h0000);
      tick();

      // Address changed by the requester mid-access.
      req[0][0]   = 1'b1;
      we[0][0]    = 1'b0;
      addr[0][0]  = 16'h0200;
      rd_word[0]  = 16'h5A5A;
      tick();
      tick();
      addr[0][0] = 16'h0300;
      tick();
      chk("addr_held", m_addr[0], 16'h0200);
      lat = -1;
      for (int n = 0; n < 10 && lat < 0; n++) begin
         tick();
         if (ack[0][0] === 1'b1) begin lat = n; req[0][0] = 1'b0; end
      end
      req[0][0] = 1'b0;
      chk("addr_change_acked", 16'(lat >= 0), 16'h0001);
      chk("addr_change_rdata", rdata[0][0], 16'h5A5A);
      tick();
      tick();

      // Reset asserted in the second access cycle.
      req[0][0]  = 1'b1;
      we[0][0]   = 1'b0;
      addr[0][0] = 16'h0400;
      tick();
      tick();
      chk("pre_reset_read_en", 16'(m_re[0]), 16'h0001);
      rst_n = 1'b0;
      req[0][0] = 1'b0;
      #1;
      reset_model();
      check_cycle();
      tick();
      tick();
      rst_n = 1'b1;
      for (int n = 0; n < 6; n++) tick();
      rd_word[0] = 16'hC3C3;
      serve(0, 0, 1'b0, 16'h0500, 16'h0000, lat);
      chk("post_reset_latency", 16'(lat), 16'(AC + 2));
      chk("post_reset_rdata", rdata[0][0], 16'hC3C3);
      tick();
      tick();

      // Continuous contention, round-robin instance.
      contend(0, 8 * (AC + 2), n0, n1);
      chk("rr_port0_grants", 16'(n0), 16'd4);
      chk("rr_port1_grants", 16'(n1), 16'd4);

      // Continuous contention, fixed-priority instance: the ack mask lets port 1 in.
      contend(1, 8 * (AC + 2), n0, n1);
      chk("fp_port0_grants", 16'(n0), 16'd4);
      chk("fp_port1_grants", 16'(n1), 16'd4);

      // Randomised traffic on both instances.
      for (int n = 0; n < 600; n++) begin
         for (int i = 0; i < 2; i++) begin
            for (int p = 0; p < 2; p++) begin
               if (req[i][p]) begin
                  if (exp_ack(i, p)) begin
                     if ($urandom_range(0, 1) == 0) new_fields(i, p);
                     else req[i][p] = 1'b0;
                  end else if ($urandom_range(0, 3) == 0) begin
                     new_fields(i, p);
                  end
               end else if ($urandom_range(0, 2) == 0) begin
                  req[i][p] = 1'b1;
                  new_fields(i, p);
               end
            end
            rd_word[i] = 16'($urandom);
         end
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
